// File: rtl/pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module : pattern_pkg
// Brief  : Shared state encodings, default parameters and width helper for
//          the pattern serializer slice.
// Rev    : 1.0 - initial release
// ============================================================================
package pattern_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int C_DEFAULT_WIDTH = 8;
    localparam int C_DEFAULT_DIV   = 10;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_serializer_if.sv
`default_nettype none
// ============================================================================
// Module : pattern_serializer_if
// Brief  : Control/data bundle between a pattern source and the serializer.
// Rev    : 1.0 - initial release
// ============================================================================
interface pattern_serializer_if
    import pattern_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
);

    logic             load;
    logic [WIDTH-1:0] pattern;
    logic             loop;
    logic             stop;
    logic             busy;
    logic             ce_out;
    logic             d_out;
    logic             done;

    modport master (
        output load, pattern, loop, stop,
        input  busy, ce_out, d_out, done
    );

    modport slave (
        input  load, pattern, loop, stop,
        output busy, ce_out, d_out, done
    );

endinterface
`default_nettype wire

// File: rtl/ce_gen.sv
`default_nettype none
// ============================================================================
// Module : ce_gen
// Brief  : Free-running 0..DIV-1 prescaler, held at zero while disabled.
// Rev    : 1.0 - initial release
// ============================================================================
module ce_gen
    import pattern_pkg::*;
#(
    parameter int DIV = C_DEFAULT_DIV
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en,
    output logic      tick
);

    localparam int CW = cnt_width(DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(DIV - 1));
    assign tick = en && wrap;

    always_comb begin
        cnt_d = '0;
        if (en && !wrap) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pattern_serializer.sv
`default_nettype none
// ============================================================================
// Module : pattern_serializer
// Brief  : MSB-first serializer of a captured word, one bit per DIV clocks,
//          with single-shot or looping operation and synchronous abort.
// Rev    : 1.0 - initial release
// ============================================================================
module pattern_serializer
    import pattern_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH,
    parameter int DIV   = C_DEFAULT_DIV
) (
    input  wire logic            clk,
    input  wire logic            rst,
    pattern_serializer_if.slave  bus
);

    localparam int IW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             loop_q, loop_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             done_q, done_d;
    logic             tick;
    logic             running;

    assign running = (state_q == RUN);

    ce_gen #(
        .DIV (DIV)
    ) u_ce_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (running),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        loop_d   = loop_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    shadow_d = bus.pattern;
                    loop_d   = bus.loop;
                    idx_d    = IW'(WIDTH - 1);
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Abort takes priority over whatever the strobe would do.
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - IW'(1);
                    end else if (loop_q) begin
                        idx_d = IW'(WIDTH - 1);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            loop_q   <= 1'b0;
            idx_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            loop_q   <= loop_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = running;
    assign bus.ce_out = tick && !bus.stop;
    assign bus.d_out  = running ? shadow_q[idx_q] : 1'b0;
    assign bus.done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_serializer.sv
`default_nettype none
// ============================================================================
// Module : tb_pattern_serializer
// Brief  : Directed self-checking bench for pattern_serializer (WIDTH=8, DIV=4)
//          with a downstream LED shift register modelled alongside.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pattern_serializer;

    localparam int WIDTH = 8;
    localparam int DIV   = 4;

    logic clk;
    logic rst;
    logic [7:0] led;
    int n_vec;
    int n_err;

    pattern_serializer_if #(.WIDTH(WIDTH)) bus ();

    pattern_serializer #(
        .WIDTH (WIDTH),
        .DIV   (DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream shift_reg_led: ce_in <= ce_out, d_in <= d_out.
    always @(posedge clk or negedge rst) begin
        if (!rst) led <= 8'h00;
        else if (bus.ce_out) led <= {led[6:0], bus.d_out};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 after the capture edge.
    task automatic start(input logic [7:0] pat, input logic lp);
        bus.load    = 1'b1;
        bus.pattern = pat;
        bus.loop    = lp;
        step();
        bus.load    = 1'b0;
    endtask

    // Walks cycles 1..33 of a single-shot transfer; returns in the done cycle.
    task automatic serial_run(input logic [7:0] exp_word, input bit inject);
        logic [7:0] got;
        got = 8'h00;
        for (int c = 1; c <= 33; c++) begin
            chk("ce_timing", bus.ce_out, ((c % 4) == 0) && (c <= 32));
            chk("busy", bus.busy, c <= 32);
            chk("done", bus.done, c == 33);
            if (bus.ce_out) got = {got[6:0], bus.d_out};
            if (inject && c == 2) begin
                bus.load    = 1'b1;
                bus.pattern = 8'hFF;
            end
            if (inject && c == 3) bus.load = 1'b0;
            if (c < 33) step();
        end
        chk("word", got, exp_word);
    endtask

    initial begin
        logic [7:0] exp81;
        int k;
        int c;
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b0;
        bus.load    = 1'b0;
        bus.pattern = 8'h00;
        bus.loop    = 1'b0;
        bus.stop    = 1'b0;

        // Reset state
        #12;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_ce", bus.ce_out, 1'b0);
        chk("rst_dout", bus.d_out, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        rst = 1'b1;
        step();

        // stop in IDLE is ignored
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("idle_stop_busy", bus.busy, 1'b0);
        chk("idle_stop_ce", bus.ce_out, 1'b0);

        // Single shot 0xA5
        start(8'hA5, 1'b0);
        serial_run(8'hA5, 1'b0);
        step();
        chk("a5_busy_after", bus.busy, 1'b0);
        chk("a5_done_after", bus.done, 1'b0);
        chk("a5_dout_idle", bus.d_out, 1'b0);

        // Loop 0x81, 20 strobes
        exp81 = 8'h81;
        k = 0;
        c = 1;
        start(8'h81, 1'b1);
        while (c <= 100 && k < 20) begin
            chk("loop_done", bus.done, 1'b0);
            if (bus.ce_out) begin
                chk("loop_bit", bus.d_out, exp81[7 - (k % 8)]);
                k++;
            end
            if (k < 20) begin
                step();
                c++;
            end
        end
        chk("loop_strobes", k, 20);
        chk("loop_last_cycle", c, 80);
        chk("loop_busy", bus.busy, 1'b1);
        step();
        bus.stop = 1'b1;
        #1;
        chk("loop_stop_ce", bus.ce_out, 1'b0);
        step();
        bus.stop = 1'b0;
        chk("loop_stop_busy", bus.busy, 1'b0);
        chk("loop_stop_done", bus.done, 1'b0);

        // stop on the third strobe
        start(8'h3C, 1'b0);
        for (int i = 2; i <= 12; i++) step();
        chk("third_strobe_pre", bus.ce_out, 1'b1);
        bus.stop = 1'b1;
        #1;
        chk("third_strobe_ce", bus.ce_out, 1'b0);
        chk("third_strobe_busy", bus.busy, 1'b1);
        step();
        bus.stop = 1'b0;
        chk("stop_idle", bus.busy, 1'b0);
        chk("stop_done", bus.done, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stop_quiet_ce", bus.ce_out, 1'b0);
            chk("stop_quiet_done", bus.done, 1'b0);
        end

        // stop wins over the final strobe
        start(8'h01, 1'b0);
        for (int i = 2; i <= 32; i++) step();
        chk("final_pre_ce", bus.ce_out, 1'b1);
        bus.stop = 1'b1;
        #1;
        chk("final_stop_ce", bus.ce_out, 1'b0);
        step();
        bus.stop = 1'b0;
        chk("final_stop_done", bus.done, 1'b0);
        chk("final_stop_busy", bus.busy, 1'b0);
        chk("final_stop_dout", bus.d_out, 1'b0);

        // Load while busy ignored; load in done cycle accepted
        start(8'h0F, 1'b0);
        serial_run(8'h0F, 1'b1);
        bus.load    = 1'b1;
        bus.pattern = 8'hFF;
        bus.loop    = 1'b0;
        step();
        bus.load    = 1'b0;
        chk("done_load_busy", bus.busy, 1'b1);
        serial_run(8'hFF, 1'b0);
        step();

        // Asynchronous reset mid-transfer
        start(8'hFF, 1'b0);
        for (int i = 2; i <= 10; i++) step();
        chk("pre_rst_busy", bus.busy, 1'b1);
        chk("pre_rst_dout", bus.d_out, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_busy", bus.busy, 1'b0);
        chk("async_rst_dout", bus.d_out, 1'b0);
        chk("async_rst_ce", bus.ce_out, 1'b0);
        chk("async_rst_done", bus.done, 1'b0);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("post_rst_ce", bus.ce_out, 1'b0);
            chk("post_rst_busy", bus.busy, 1'b0);
        end

        // Chained with LED shift register
        start(8'hA5, 1'b0);
        serial_run(8'hA5, 1'b0);
        chk("led_value", led, 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
